// File: rtl/pixel_shadow_buffer.sv
// Shadow copy of the 160x120 VGA frame buffer: mirrors drawer writes, serves pipelined
// colour reads for game logic, and self-clears after reset or on request.
module pixel_shadow_buffer #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [2:0] colour,
    input  logic       writeEn,
    input  logic       clear_start,
    output logic       busy,
    input  logic       rd_req,
    input  logic [9:0] rd_x,
    input  logic [9:0] rd_y,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [2:0] rd_colour,
    output logic [7:0] oob_count
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [9:0]  WIDTH_L   = 10'(WIDTH);
    localparam logic [9:0]  HEIGHT_L  = 10'(HEIGHT);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t      state_q, state_d;
    logic [14:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]  oob_q, oob_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s1_in_range_q, s1_in_range_d;
    logic        rd_valid_q, rd_valid_d;
    logic [2:0]  rd_colour_q, rd_colour_d;
    logic [2:0]  ram_dout_q;

    logic [2:0]  mem [0:DEPTH-1];
    logic        mem_we;
    logic [14:0] mem_waddr;
    logic [2:0]  mem_wdata;

    logic        wr_in_range, rd_in_range, rd_accept, ram_re;
    logic [14:0] wr_addr, rd_addr;

    // y*160 + x as (y<<7) + (y<<5) + x; only the low 7 bits of y matter once in range.
    assign wr_addr = {1'b0, y[6:0], 7'b0} + {3'b0, y[6:0], 5'b0} + {5'b0, x};
    assign rd_addr = {1'b0, rd_y[6:0], 7'b0} + {3'b0, rd_y[6:0], 5'b0} + {5'b0, rd_x};

    assign wr_in_range = (x < WIDTH_L) && (y < HEIGHT_L);
    assign rd_in_range = (rd_x < WIDTH_L) && (rd_y < HEIGHT_L);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        oob_d     = oob_q;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLEAR_COLOUR;
        busy      = 1'b0;
        rd_ready  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 15'd1;
                end
            end
            S_IDLE: begin
                rd_ready = 1'b1;
                if (writeEn) begin
                    if (wr_in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_addr;
                        mem_wdata = colour;
                    end else if (oob_q != 8'hFF) begin
                        oob_d = oob_q + 8'd1;
                    end
                end
                // A write in the same cycle still lands; the clear overwrites it later.
                if (clear_start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = 15'd0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        rd_accept     = rd_req && rd_ready;
        ram_re        = rd_accept && rd_in_range;
        s1_valid_d    = rd_accept;
        s1_in_range_d = rd_in_range;
        rd_valid_d    = s1_valid_q;
        rd_colour_d   = rd_colour_q;
        if (s1_valid_q) begin
            rd_colour_d = s1_in_range_q ? ram_dout_q : CLEAR_COLOUR;
        end
    end

    // Read and write share one edge; the nonblocking read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (ram_re) begin
            ram_dout_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            clr_cnt_q     <= 15'd0;
            oob_q         <= 8'd0;
            s1_valid_q    <= 1'b0;
            s1_in_range_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_colour_q   <= 3'b000;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            oob_q         <= oob_d;
            s1_valid_q    <= s1_valid_d;
            s1_in_range_q <= s1_in_range_d;
            rd_valid_q    <= rd_valid_d;
            rd_colour_q   <= rd_colour_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_colour = rd_colour_q;
    assign oob_count = oob_q;

endmodule

// File: tb/tb_pixel_shadow_buffer.sv
// Bench for pixel_shadow_buffer: reference pixel model plus an expected-read queue
// matched against rd_valid pulses, with exact latency checks.
module tb_pixel_shadow_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y, rd_x, rd_y;
    logic [2:0] colour, rd_colour;
    logic       writeEn, clear_start, rd_req;
    logic       busy, rd_ready, rd_valid;
    logic [7:0] oob_count;

    pixel_shadow_buffer dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .clear_start(clear_start), .busy(busy), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_colour(rd_colour), .oob_count(oob_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_oob = 0;
    logic [2:0] exp_q[$];
    int         due_q[$];
    logic [2:0] model [0:19199];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 19200; i++) model[i] = 3'b000;
    endtask

    function automatic logic [2:0] model_rd(input int px, input int py);
        if (px < 160 && py < 120) return model[py * 160 + px];
        return 3'b000;
    endfunction

    task automatic wr(input int px, input int py, input logic [2:0] c);
        x = px[9:0]; y = py[9:0]; colour = c; writeEn = 1'b1;
        @(negedge clk);
        writeEn = 1'b0;
        if (px < 160 && py < 120) model[py * 160 + px] = c;
        else if (exp_oob < 255) exp_oob++;
    endtask

    task automatic rd(input int px, input int py);
        rd_x = px[9:0]; rd_y = py[9:0]; rd_req = 1'b1;
        exp_q.push_back(model_rd(px, py));
        due_q.push_back(cyc + 2);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic wait_clear(input int start, input string tag);
        int n;
        n = start;
        while (busy && n < 25000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, 19200);
        model_clear();
    endtask

    // Read response monitor: order, colour and exact arrival cycle.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", rd_valid, 0);
            end else begin
                check("rd_colour", rd_colour, exp_q.pop_front());
                check("rd_latency", cyc, due_q.pop_front());
            end
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            check("rd_missing", rd_valid, 1);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int px, py;
        logic [2:0] c;
        reset = 1'b1; x = 0; y = 0; colour = 0; writeEn = 0; clear_start = 0;
        rd_req = 0; rd_x = 0; rd_y = 0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 1);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_colour", rd_colour, 0);
        check("rst_oob", oob_count, 0);
        wait_clear(0, "init_clear_cycles");
        check("idle_rd_ready", rd_ready, 1);

        rd(0, 0);
        rd(159, 119);
        wr(32, 64, 3'b100);
        rd(32, 64);
        rd(33, 64);

        wr(160, 0, 3'b111);
        wr(0, 120, 3'b111);
        check("oob_two", oob_count, exp_oob);
        rd(160, 0);
        rd(0, 0);
        for (int i = 0; i < 300; i++) wr($urandom_range(160, 1023), $urandom_range(0, 1023), 3'b111);
        check("oob_saturate", oob_count, exp_oob);
        check("oob_255", exp_oob, 255);

        wr(0, 0, 3'b001);
        wr(1, 0, 3'b010);
        wr(2, 0, 3'b011);
        rd(0, 0);
        rd(1, 0);
        rd(2, 0);

        // Same-cycle write and read of (5,5): the read sees the old value.
        x = 10'd5; y = 10'd5; colour = 3'b010; writeEn = 1'b1;
        rd_x = 10'd5; rd_y = 10'd5; rd_req = 1'b1;
        exp_q.push_back(model_rd(5, 5));
        due_q.push_back(cyc + 2);
        @(negedge clk);
        writeEn = 1'b0; rd_req = 1'b0;
        model[5 * 160 + 5] = 3'b010;
        rd(5, 5);

        for (int i = 0; i < 30; i++) begin
            px = $urandom_range(0, 159);
            py = $urandom_range(0, 119);
            c  = 3'($urandom_range(0, 7));
            wr(px, py, c);
            rd(px, py);
            rd($urandom_range(0, 159), $urandom_range(0, 119));
        end

        // Clear request together with a read: the read completes with the old value.
        clear_start = 1'b1;
        rd_x = 10'd32; rd_y = 10'd64; rd_req = 1'b1;
        exp_q.push_back(model_rd(32, 64));
        due_q.push_back(cyc + 2);
        @(negedge clk);
        clear_start = 1'b0; rd_req = 1'b0;
        check("clr_busy", busy, 1);
        check("clr_rd_ready", rd_ready, 0);
        x = 10'd7; y = 10'd7; colour = 3'b101; writeEn = 1'b1;
        rd_x = 10'd7; rd_y = 10'd7; rd_req = 1'b1;
        @(negedge clk);
        writeEn = 1'b0; rd_req = 1'b0;
        wait_clear(1, "clear_start_cycles");
        rd(32, 64);
        rd(0, 0);
        rd(5, 5);
        rd(7, 7);
        for (int i = 0; i < 8; i++) rd($urandom_range(0, 159), $urandom_range(0, 119));
        repeat (4) @(negedge clk);

        // Read accepted, then reset before it completes: no response.
        rd_x = 10'd1; rd_y = 10'd0; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_oob = 0;
        check("rst2_oob", oob_count, exp_oob);
        check("rst2_busy", busy, 1);
        rd_x = 10'd3; rd_y = 10'd3; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (99) @(negedge clk);
        check("clear_cycle100_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_clear(0, "restart_clear_cycles");
        rd(0, 0);
        rd(159, 119);
        repeat (5) @(negedge clk);
        check("drain", due_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
